simd_shader_core: RTL and testbench

Parametrised multi-lane SIMD shader core: one shared instruction stream, `NUM_LANES` lanes each with a private register file, a two-stage fetch/execute pipeline, run/halt control and a debug read port. It is the next generation of `shader_pipeline`. Over that block it adds:
- lane count and data width as parameters;
- a loadable instruction memory;
- an explicit start/done handshake;
- a HALT instruction;
- a retired-instruction counter.

It sits under the top-level shader wrapper. A host loads programs and reads results over the same ports the bench uses.

---
 rtl/shader_pkg.sv | 53 +++++
 rtl/shader_lane.sv | 58 +++++
 rtl/simd_shader_core.sv | 125 ++++++++++++
 tb/tb_simd_shader_core.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shader_pkg.sv
// Shared definitions for the SIMD shader core: opcodes, instruction field
// positions, register-file size, the control FSM state encoding and the
// decoded-instruction struct handed from the top level to every lane.
package shader_pkg;

    localparam int NUM_REGS = 4;
    localparam int REG_W    = 2;
    localparam int INSTR_W  = 16;

    // Opcodes (op field). 9..E are unassigned and execute as NOP.
    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_LDI    = 4'h1;
    localparam logic [3:0] OP_ADD    = 4'h2;
    localparam logic [3:0] OP_SUB    = 4'h3;
    localparam logic [3:0] OP_MUL    = 4'h4;
    localparam logic [3:0] OP_AND    = 4'h5;
    localparam logic [3:0] OP_OR     = 4'h6;
    localparam logic [3:0] OP_XOR    = 4'h7;
    localparam logic [3:0] OP_LANEID = 4'h8;
    localparam logic [3:0] OP_HALT   = 4'hF;

    // Field positions; imm overlaps rs2 and the unused low bits.
    localparam int OP_LO  = 12;
    localparam int RD_LO  = 10;
    localparam int RS1_LO = 8;
    localparam int RS2_LO = 6;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]       op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [7:0]       imm;
    } instr_t;

    function automatic instr_t decode(input logic [INSTR_W-1:0] w);
        instr_t d;
        d.op  = w[OP_LO  +: 4];
        d.rd  = w[RD_LO  +: REG_W];
        d.rs1 = w[RS1_LO +: REG_W];
        d.rs2 = w[RS2_LO +: REG_W];
        d.imm = w[IMM_LO +: 8];
        return d;
    endfunction

endpackage

// File: rtl/shader_lane.sv
// One SIMD lane: 4 x DATA_W register file, ALU and write port, plus a
// combinational debug read port.
// Ports:
//   clk, rst_n    clock / async active-low reset (clears the register file)
//   i_exec        execute i_instr this cycle
//   i_instr       decoded instruction shared by all lanes
//   i_dbg_reg     debug register select
//   o_dbg_data    register[i_dbg_reg]
module shader_lane
    import shader_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int LANE_ID = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_exec,
    input  instr_t            i_instr,
    input  logic [REG_W-1:0]  i_dbg_reg,
    output logic [DATA_W-1:0] o_dbg_data
);

    logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
    logic [DATA_W-1:0] w_a, w_b, w_res;
    logic              w_we;

    // Operands are read in the execute cycle, so a back-to-back dependent
    // instruction sees the value written at the previous edge.
    assign w_a = r_regs[i_instr.rs1];
    assign w_b = r_regs[i_instr.rs2];

    always_comb begin
        w_we  = 1'b1;
        w_res = '0;
        case (i_instr.op)
            OP_LDI:    w_res = DATA_W'(i_instr.imm);
            OP_ADD:    w_res = w_a + w_b;
            OP_SUB:    w_res = w_a - w_b;
            OP_MUL:    w_res = w_a * w_b;
            OP_AND:    w_res = w_a & w_b;
            OP_OR:     w_res = w_a | w_b;
            OP_XOR:    w_res = w_a ^ w_b;
            OP_LANEID: w_res = DATA_W'(LANE_ID);
            default:   w_we  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs <= '0;
        end else if (i_exec && w_we) begin
            r_regs[i_instr.rd] <= w_res;
        end
    end

    assign o_dbg_data = r_regs[i_dbg_reg];

endmodule

// File: rtl/simd_shader_core.sv
// Multi-lane SIMD shader core: loadable instruction memory, two-stage
// fetch/execute pipeline, IDLE/RUN/DONE control with start/done handshake,
// HALT, saturating retired-instruction counter and a debug read mux.
// Ports:
//   clk, rst_n                        clock / async active-low reset
//   start                             begin at address 0 (IDLE/DONE only)
//   imem_we/imem_waddr/imem_wdata     instruction write (ignored while busy)
//   dbg_lane/dbg_reg -> dbg_data      combinational register readback
//   pc, busy, done, retired           status
module simd_shader_core
    import shader_pkg::*;
#(
    parameter  int NUM_LANES  = 4,
    parameter  int DATA_W     = 16,
    parameter  int IMEM_DEPTH = 16,
    parameter  int PC_W       = $clog2(IMEM_DEPTH),
    localparam int LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               imem_we,
    input  logic [PC_W-1:0]    imem_waddr,
    input  logic [INSTR_W-1:0] imem_wdata,
    input  logic [LANE_W-1:0]  dbg_lane,
    input  logic [REG_W-1:0]   dbg_reg,
    output logic [DATA_W-1:0]  dbg_data,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               done,
    output logic [15:0]        retired
);

    state_t               r_state, w_next;
    logic [INSTR_W-1:0]   r_imem [IMEM_DEPTH];
    logic [INSTR_W-1:0]   r_ir;
    logic                 r_ir_valid;
    logic [PC_W-1:0]      r_pc;
    logic [15:0]          r_retired;
    instr_t               w_ir;
    logic                 w_exec, w_halt, w_launch;

    logic [NUM_LANES-1:0][DATA_W-1:0] w_lane_dbg;

    assign w_ir     = decode(r_ir);
    assign w_exec   = (r_state == ST_RUN) && r_ir_valid;
    assign w_halt   = w_exec && (w_ir.op == OP_HALT);
    assign w_launch = (r_state != ST_RUN) && start;

    // ---- FSM: state register / next state / outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start)  w_next = ST_RUN;
            ST_RUN:           if (w_halt) w_next = ST_DONE;
            default:          w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == ST_RUN);
        done = (r_state == ST_DONE);
    end

    // ---- instruction memory (not reset; writes locked out in RUN) ----
    always_ff @(posedge clk) begin
        if (imem_we && (r_state != ST_RUN)) r_imem[imem_waddr] <= imem_wdata;
    end

    // ---- fetch / pc / retired ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= '0;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_retired  <= '0;
        end else if (w_launch) begin
            r_pc       <= '0;
            r_ir_valid <= 1'b0;
            r_retired  <= '0;
        end else if (r_state == ST_RUN) begin
            if (w_exec && (r_retired != 16'hFFFF)) r_retired <= r_retired + 16'd1;
            // HALT drops the fetch of the same cycle and freezes pc just past it.
            if (w_halt) begin
                r_ir_valid <= 1'b0;
            end else begin
                r_ir       <= r_imem[r_pc];
                r_ir_valid <= 1'b1;
                r_pc       <= r_pc + PC_W'(1);
            end
        end
    end

    assign pc      = r_pc;
    assign retired = r_retired;

    // ---- lanes ----
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        shader_lane #(
            .DATA_W  (DATA_W),
            .LANE_ID (g)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_exec     (w_exec),
            .i_instr    (w_ir),
            .i_dbg_reg  (dbg_reg),
            .o_dbg_data (w_lane_dbg[g])
        );
    end

    // Compare-based select keeps out-of-range lane numbers reading zero.
    always_comb begin
        dbg_data = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (dbg_lane == LANE_W'(i)) dbg_data = w_lane_dbg[i];
        end
    end

endmodule

// File: tb/tb_simd_shader_core.sv
module tb_simd_shader_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 4 lanes, 16-bit, 16-word imem
    logic        rst_n = 1'b0, start = 1'b0, imem_we = 1'b0;
    logic [3:0]  imem_waddr = '0;
    logic [15:0] imem_wdata = '0;
    logic [1:0]  dbg_lane = '0, dbg_reg = '0;
    logic [15:0] dbg_data, retired;
    logic [3:0]  pc;
    logic        busy, done;

    // DUT B: 2 lanes, 8-bit, 4-word imem
    logic        rst_nb = 1'b0, start_b = 1'b0, we_b = 1'b0;
    logic [1:0]  waddr_b = '0;
    logic [15:0] wdata_b = '0;
    logic [0:0]  dbg_lane_b = '0;
    logic [1:0]  dbg_reg_b = '0;
    logic [7:0]  dbg_data_b;
    logic [1:0]  pc_b;
    logic        busy_b, done_b;
    logic [15:0] retired_b;

    simd_shader_core #(.NUM_LANES(4), .DATA_W(16), .IMEM_DEPTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .dbg_lane(dbg_lane),
        .dbg_reg(dbg_reg), .dbg_data(dbg_data), .pc(pc), .busy(busy),
        .done(done), .retired(retired));

    simd_shader_core #(.NUM_LANES(2), .DATA_W(8), .IMEM_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_nb), .start(start_b), .imem_we(we_b),
        .imem_waddr(waddr_b), .imem_wdata(wdata_b), .dbg_lane(dbg_lane_b),
        .dbg_reg(dbg_reg_b), .dbg_data(dbg_data_b), .pc(pc_b), .busy(busy_b),
        .done(done_b), .retired(retired_b));

    // kinds: 0 pc, 1 busy, 2 done, 3 retired, 4 register, 5 start-to-done cycles
    typedef struct {
        string name;
        int    d;
        int    kind;
        int    lane;
        int    rg;
        int    exp;
    } chk_t;

    chk_t q[$];
    int   req_cnt = 0, ack_cnt = 0;
    int   n_cmp = 0, n_bad = 0;
    int   lat = 0;

    function automatic logic [15:0] rr(input int op, input int rd, input int rs1, input int rs2);
        logic [15:0] w;
        w = {op[3:0], rd[1:0], rs1[1:0], rs2[1:0], 6'b0};
        return w;
    endfunction

    function automatic logic [15:0] ldi(input int rd, input int imm);
        logic [15:0] w;
        w = {4'h1, rd[1:0], 2'b00, imm[7:0]};
        return w;
    endfunction

    localparam logic [15:0] HALT = 16'hF000;
    localparam logic [15:0] NOP  = 16'h0000;

    task automatic expect_v(input string name, input int d, input int kind,
                            input int lane, input int rg, input int exp);
        chk_t c;
        c.name = name; c.d = d; c.kind = kind; c.lane = lane; c.rg = rg; c.exp = exp;
        q.push_back(c);
    endtask

    task automatic flush();
        req_cnt++;
        wait (ack_cnt == req_cnt);
    endtask

    // Monitor: drains queued expectations against what the DUT presents.
    initial begin
        chk_t c;
        int   act;
        forever begin
            wait (req_cnt != ack_cnt);
            while (q.size() > 0) begin
                c = q.pop_front();
                act = 0;
                case (c.kind)
                    0: act = (c.d == 0) ? int'(pc) : int'(pc_b);
                    1: act = (c.d == 0) ? int'(busy) : int'(busy_b);
                    2: act = (c.d == 0) ? int'(done) : int'(done_b);
                    3: act = (c.d == 0) ? int'(retired) : int'(retired_b);
                    4: begin
                        if (c.d == 0) begin
                            dbg_lane = c.lane[1:0]; dbg_reg = c.rg[1:0]; #1;
                            act = int'(dbg_data);
                        end else begin
                            dbg_lane_b = c.lane[0:0]; dbg_reg_b = c.rg[1:0]; #1;
                            act = int'(dbg_data_b);
                        end
                    end
                    default: act = lat;
                endcase
                n_cmp++;
                if (act != c.exp) begin
                    n_bad++;
                    $display("FAIL %s (lane %0d reg %0d): got 0x%0h, expected 0x%0h",
                             c.name, c.lane, c.rg, act, c.exp);
                end
            end
            ack_cnt++;
        end
    end

    task automatic load(input int d, input int addr, input logic [15:0] w);
        @(negedge clk);
        if (d == 0) begin imem_we = 1'b1; imem_waddr = addr[3:0]; imem_wdata = w; end
        else        begin we_b = 1'b1;    waddr_b = addr[1:0];    wdata_b = w;    end
        @(negedge clk);
        imem_we = 1'b0; we_b = 1'b0;
    endtask

    // Returns #1 after the edge that samples start.
    task automatic go(input int d);
        @(negedge clk);
        if (d == 0) start = 1'b1; else start_b = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start_b = 1'b0;
    endtask

    task automatic wait_done(input int d);
        lat = 0;
        while (!((d == 0) ? done : done_b) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!((d == 0) ? done : done_b)) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout dut%0d: done never rose within %0d cycles", d, lat);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        expect_v("rst_pc", 0, 0, 0, 0, 0);
        expect_v("rst_busy", 0, 1, 0, 0, 0);
        expect_v("rst_done", 0, 2, 0, 0, 0);
        expect_v("rst_retired", 0, 3, 0, 0, 0);
        for (int l = 0; l < 4; l++)
            for (int r = 0; r < 4; r++) expect_v("rst_reg", 0, 4, l, r, 0);
        expect_v("rst_b_pc", 1, 0, 0, 0, 0);
        expect_v("rst_b_busy", 1, 1, 0, 0, 0);
        flush();
        @(negedge clk); rst_n = 1'b1; rst_nb = 1'b1;

        // ---------------- basic program ----------------
        load(0, 0, ldi(0, 5));
        load(0, 1, ldi(1, 3));
        load(0, 2, rr(2, 2, 0, 1));
        load(0, 3, rr(3, 3, 0, 1));
        load(0, 4, HALT);
        go(0);
        expect_v("basic_busy_after_start", 0, 1, 0, 0, 1);
        expect_v("basic_pc_after_start", 0, 0, 0, 0, 0);
        flush();
        wait_done(0);
        expect_v("basic_latency", 0, 5, 0, 0, 6);
        expect_v("basic_done", 0, 2, 0, 0, 1);
        expect_v("basic_busy", 0, 1, 0, 0, 0);
        expect_v("basic_retired", 0, 3, 0, 0, 5);
        expect_v("basic_pc", 0, 0, 0, 0, 5);
        for (int l = 0; l < 4; l++) begin
            expect_v("basic_r2", 0, 4, l, 2, 16'h0008);
            expect_v("basic_r3", 0, 4, l, 3, 16'h0002);
        end
        flush();

        // ---------------- per-lane values, persistence ----------------
        load(0, 0, rr(8, 0, 0, 0));
        load(0, 1, ldi(1, 2));
        load(0, 2, rr(4, 2, 0, 1));
        load(0, 3, HALT);
        go(0);
        wait_done(0);
        expect_v("lane_latency", 0, 5, 0, 0, 5);
        expect_v("lane_retired", 0, 3, 0, 0, 4);
        expect_v("lane_pc", 0, 0, 0, 0, 4);
        for (int l = 0; l < 4; l++) begin
            expect_v("lane_r0_id", 0, 4, l, 0, l);
            expect_v("lane_r2_mul", 0, 4, l, 2, 2 * l);
            expect_v("lane_r3_persist", 0, 4, l, 3, 2);
        end
        flush();

        // ---------------- start / imem_we ignored while busy ----------------
        load(0, 0, ldi(0, 0));
        load(0, 1, ldi(1, 1));
        for (int a = 2; a < 10; a++) load(0, a, rr(2, 0, 0, 1));
        load(0, 10, HALT);
        go(0);
        repeat (3) @(negedge clk);
        start = 1'b1; imem_we = 1'b1; imem_waddr = 4'd10; imem_wdata = NOP;
        @(negedge clk);
        start = 1'b0; imem_we = 1'b0;
        expect_v("busy_mid_run", 0, 1, 0, 0, 1);
        flush();
        @(negedge clk);
        expect_v("retired_no_restart", 0, 3, 0, 0, 3);
        flush();
        wait_done(0);
        expect_v("ign_retired", 0, 3, 0, 0, 11);
        expect_v("ign_pc", 0, 0, 0, 0, 11);
        expect_v("ign_r0", 0, 4, 1, 0, 8);
        flush();
        go(0);
        wait_done(0);
        expect_v("readback_latency", 0, 5, 0, 0, 12);
        expect_v("readback_retired", 0, 3, 0, 0, 11);
        expect_v("readback_r0", 0, 4, 3, 0, 8);
        flush();

        // ---------------- reset mid-run ----------------
        go(0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0; #1;
        expect_v("midrst_busy", 0, 1, 0, 0, 0);
        expect_v("midrst_done", 0, 2, 0, 0, 0);
        expect_v("midrst_pc", 0, 0, 0, 0, 0);
        expect_v("midrst_retired", 0, 3, 0, 0, 0);
        for (int l = 0; l < 4; l++)
            for (int r = 0; r < 4; r++) expect_v("midrst_reg", 0, 4, l, r, 0);
        flush();
        @(negedge clk); rst_n = 1'b1;
        go(0);
        wait_done(0);
        expect_v("rerun_retired", 0, 3, 0, 0, 11);
        expect_v("rerun_pc", 0, 0, 0, 0, 11);
        expect_v("rerun_r0", 0, 4, 2, 0, 8);
        expect_v("rerun_r1", 0, 4, 2, 1, 1);
        expect_v("rerun_r3_cleared", 0, 4, 2, 3, 0);
        flush();

        // ---------------- DATA_W=8 wrap, HALT at last address ----------------
        load(1, 0, ldi(0, 8'hFF));
        load(1, 1, ldi(1, 2));
        load(1, 2, rr(2, 2, 0, 1));
        load(1, 3, HALT);
        go(1);
        wait_done(1);
        expect_v("b_latency", 1, 5, 0, 0, 5);
        expect_v("b_retired", 1, 3, 0, 0, 4);
        expect_v("b_pc_wrap", 1, 0, 0, 0, 0);
        for (int l = 0; l < 2; l++) begin
            expect_v("b_r0", 1, 4, l, 0, 8'hFF);
            expect_v("b_r2_wrap", 1, 4, l, 2, 8'h01);
        end
        flush();

        // ---------------- no-HALT program: pc wraps, stays busy ----------------
        for (int a = 0; a < 4; a++) load(1, a, NOP);
        go(1);
        expect_v("nohalt_pc", 1, 0, 0, 0, 0);
        expect_v("nohalt_busy", 1, 1, 0, 0, 1);
        flush();
        for (int m = 1; m <= 5; m++) begin
            @(posedge clk); #1;
            expect_v("nohalt_pc", 1, 0, 0, 0, m % 4);
            expect_v("nohalt_busy", 1, 1, 0, 0, 1);
            flush();
        end
        expect_v("nohalt_retired", 1, 3, 0, 0, 4);
        flush();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
